demux_rr_sequencer: RTL and testbench
=====================================

Name: demux_rr_sequencer

Overview:
- Upstream control stage for the 1-to-8 demultiplexer.
- Round-robin schedules eight requesting channels and drives the demux select and data input.
- Each granted channel is held for a programmable dwell time before the pointer advances.
- Produces per-grant completion and round-wrap strobes for downstream bookkeeping.

Parameters:
- N_CH, 8, number of channels; the select width is fixed at 3 for N_CH=8.
- DWELL_W, 8, width of the dwell-length input and internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  permits new grants; does not abort a dwell already in progress
- flush  input  1  synchronous abort of the current dwell
- req  input  8  per-channel request vector; bit k = channel k wants service
- dwell_len  input  DWELL_W  dwell length in cycles, sampled at grant; value 0 is treated as 1
- din  input  1  serial data bit to be routed
- sel  output  3  registered demux select, equal to the granted channel index
- demux_i  output  1  demux data input; combinational, din AND active
- active  output  1  high while a channel is granted
- done  output  1  one-cycle pulse on the last active cycle of a grant
- wrap  output  1  one-cycle pulse on the first active cycle of a grant that starts a new round

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, sel=0, active=0, done=0, wrap=0.
  - pointer ptr=0, dwell counter=0, has_prev=0, prev_idx=0.
- Arbitration (combinational):
  - pick = first set bit of req, scanning ptr, ptr+1, ... wrapping modulo 8.
  - Arbitration is valid only when |req=1.
- States:
  - IDLE: if en=1 and |req=1 then, next edge: sel=pick, active=1, counter=max(dwell_len,1), state=DWELL.
  - IDLE otherwise: stay in IDLE; sel holds its last value.
  - DWELL: counter decrements each cycle; sel is frozen.
  - DWELL: changes to req or dwell_len are ignored until the last active cycle.
- Last active cycle (counter==1):
  - done=1; ptr updates to sel+1 mod 8.
  - Arbitration uses req as seen in that cycle, with the start index equal to the updated ptr.
  - If en=1 and the masked request is nonzero: back-to-back grant, no idle gap; the next cycle has new sel, active=1, fresh counter.
  - Otherwise: next cycle state=IDLE, active=0, sel holds.
- Dwell length:
  - active is high for exactly D = max(dwell_len,1) consecutive cycles per grant.
  - dwell_len=1 gives done on every active cycle.
- wrap:
  - Asserted on the first active cycle of a grant when has_prev=1 and new index <= prev_idx.
  - The first grant after reset or flush never wraps.
  - A lone requester re-granted gives wrap on every grant.
- flush (highest priority after reset):
  - Next edge: state=IDLE, active=0, done=0, wrap=0, counter=0, has_prev=0.
  - ptr is retained; no done pulse for the aborted grant.
- en=0 mid-dwell: the dwell completes with done; no re-grant follows.
- req bit of the granted channel dropping mid-dwell: ignored; the dwell completes.
- demux_i is 0 whenever active=0.
- Reset asserted mid-dwell:
  - Immediate asynchronous clear; outputs are 0 before the next edge.
- Counter and ptr arithmetic: unsigned, wrap modulo 2^DWELL_W and modulo 8 respectively; no saturation is needed because the counter is loaded to at least 1.

Test Plan:
- Single channel, back-to-back grants: rst_n released, en=1, req=8'b0000_0100, dwell_len=3 -> sel=2, active high from cycle 1; done on cycles 3, 6, 9; wrap on cycles 4 and 7, not on cycle 1.
- Round-robin fairness: req=8'b1000_0011, dwell_len=2 -> grant order 0,1,7,0,1,...; each grant is 2 active cycles; wrap coincides with each return to channel 0 after 7.
- Zero dwell: dwell_len=0, req=8'hFF -> sel steps 0..7 one per cycle; done continuous; wrap at each re-grant of channel 0.
- Abort: flush pulsed in the 2nd cycle of a 5-cycle dwell on channel 3 -> active=0 the next cycle, no done, ptr stays 4; next grant with req=8'hFF is channel 4 with wrap=0.
- en drop and reset: en=0 during a dwell on channel 5 -> done fires, then active=0 and sel stays 5.
  - rst_n low mid-dwell -> sel=0, active=0 immediately, with no clock edge.
- Data gating: din toggling every cycle -> demux_i equals din only while active=1, and 0 otherwise.

Source files
------------

// File: rtl/demux_rr_if.sv
// Control/data bundle between the round-robin sequencer and its driver.
// Master drives requests and data; slave returns select and strobes.
interface demux_rr_if #(
  parameter int N_CH    = 8,
  parameter int DWELL_W = 8
);
  localparam int SW = $clog2(N_CH);

  logic               en;
  logic               flush;
  logic [N_CH-1:0]    req;
  logic [DWELL_W-1:0] dwell_len;
  logic               din;
  logic [SW-1:0]      sel;
  logic               demux_i;
  logic               active;
  logic               done;
  logic               wrap;

  modport master (
    output en, flush, req, dwell_len, din,
    input  sel, demux_i, active, done, wrap
  );

  modport slave (
    input  en, flush, req, dwell_len, din,
    output sel, demux_i, active, done, wrap
  );
endinterface

// File: rtl/demux_rr_sequencer.sv
// Round-robin grant sequencer with programmable dwell in front of a 1:8
// demux; emits per-grant done and round-wrap strobes.
module demux_rr_sequencer #(
  parameter int N_CH    = 8,
  parameter int DWELL_W = 8
) (
  input logic        clk,
  input logic        rst_n,
  demux_rr_if.slave  bus
);
  localparam int SW = $clog2(N_CH);

  typedef enum logic {IDLE, DWELL} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [SW-1:0]      prev_q, prev_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               has_prev_q, has_prev_d;
  logic               wrap_q, wrap_d;

  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic          found;
  logic          last;
  logic          grant;

  // ptr already holds sel+1 from grant time, so it is the scan origin
  always_comb begin
    pick  = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr_q + SW'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign last  = (state_q == DWELL) && (cnt_q == DWELL_W'(1));
  assign grant = bus.en && found && ((state_q == IDLE) || last);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    has_prev_d = has_prev_q;
    wrap_d     = 1'b0;
    if (bus.flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      has_prev_d = 1'b0;
    end else if (grant) begin
      state_d    = DWELL;
      sel_d      = pick;
      ptr_d      = pick + SW'(1);
      prev_d     = pick;
      has_prev_d = 1'b1;
      wrap_d     = has_prev_q && (pick <= prev_q);
      cnt_d      = (bus.dwell_len == '0) ? DWELL_W'(1)
                                         : bus.dwell_len;
    end else if (last) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == DWELL) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      has_prev_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      has_prev_q <= has_prev_d;
      wrap_q     <= wrap_d;
    end
  end

  // an aborted grant never reports completion
  assign bus.sel     = sel_q;
  assign bus.active  = (state_q == DWELL);
  assign bus.done    = last && !bus.flush;
  assign bus.wrap    = wrap_q;
  assign bus.demux_i = bus.din && (state_q == DWELL);
endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Bench for demux_rr_sequencer: directed literal scenarios plus a
// randomized run against a behavioural grant model.
module tb_demux_rr_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   cmp_on = 1'b0;

  demux_rr_if #(.N_CH(8), .DWELL_W(8)) bus ();

  demux_rr_sequencer #(.N_CH(8), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // model state: busy flag, granted channel, cycles left, scan origin
  int m_busy = 0;
  int m_ch   = 0;
  int m_left = 0;
  int m_next = 0;
  int m_last = -1;
  int m_wrap = 0;

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge rst_n) begin
    m_busy = 0; m_ch = 0; m_left = 0;
    m_next = 0; m_last = -1; m_wrap = 0;
  end

  always @(posedge clk) begin
    int c;
    int dl;
    bit can;
    if (rst_n) begin
      if (bus.flush) begin
        m_busy = 0; m_left = 0; m_last = -1; m_wrap = 0;
      end else begin
        can = bus.en && (bus.req != 0) && (m_busy == 0 || m_left == 1);
        if (can) begin
          c = -1;
          for (int k = 0; k < 8; k++)
            if (c < 0 && bus.req[(m_next + k) % 8]) c = (m_next + k) % 8;
          dl = int'(bus.dwell_len);
          m_wrap = (m_last >= 0 && c <= m_last) ? 1 : 0;
          m_busy = 1;
          m_ch   = c;
          m_left = (dl == 0) ? 1 : dl;
          m_next = (c + 1) % 8;
          m_last = c;
        end else begin
          m_wrap = 0;
          if (m_busy != 0) begin
            m_left--;
            if (m_left == 0) m_busy = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_active", int'(bus.active), m_busy);
      chk("m_sel", int'(bus.sel), m_ch);
      chk("m_done", int'(bus.done),
          (m_busy != 0 && m_left == 1 && !bus.flush) ? 1 : 0);
      chk("m_wrap", int'(bus.wrap), m_wrap);
      chk("m_demux", int'(bus.demux_i), (bus.din && m_busy != 0) ? 1 : 0);
    end
  end

  initial begin
    bus.din = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.din = ~bus.din;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(logic [7:0] r, logic [7:0] d);
    step();
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.flush = 1'b0;
    bus.req = r;
    bus.dwell_len = d;
    @(negedge clk);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_active", int'(bus.active), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wrap", int'(bus.wrap), 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ord[3];
    int g;
    ord[0] = 0; ord[1] = 1; ord[2] = 7;
    bus.en = 1'b0;
    bus.flush = 1'b0;
    bus.req = '0;
    bus.dwell_len = '0;
    #1 rst_n = 1'b0;
    step();
    cmp_on = 1'b1;

    // lone requester, dwell 3
    do_reset(8'b0000_0100, 8'd3);
    for (int c = 1; c <= 9; c++) begin
      step();
      @(negedge clk);
      chk("s1_active", int'(bus.active), 1);
      chk("s1_sel", int'(bus.sel), 2);
      chk("s1_done", int'(bus.done), (c % 3 == 0) ? 1 : 0);
      chk("s1_wrap", int'(bus.wrap), (c == 4 || c == 7) ? 1 : 0);
    end

    // fairness over channels 0,1,7
    do_reset(8'b1000_0011, 8'd2);
    for (int c = 1; c <= 12; c++) begin
      step();
      @(negedge clk);
      g = (c - 1) / 2;
      chk("s2_sel", int'(bus.sel), ord[g % 3]);
      chk("s2_done", int'(bus.done), (c % 2 == 0) ? 1 : 0);
      chk("s2_wrap", int'(bus.wrap),
          ((c - 1) % 2 == 0 && g > 0 && g % 3 == 0) ? 1 : 0);
    end

    // zero dwell behaves as one
    do_reset(8'hFF, 8'd0);
    for (int c = 1; c <= 17; c++) begin
      step();
      @(negedge clk);
      chk("s3_sel", int'(bus.sel), (c - 1) % 8);
      chk("s3_done", int'(bus.done), 1);
      chk("s3_wrap", int'(bus.wrap), (c > 1 && (c - 1) % 8 == 0) ? 1 : 0);
    end

    // flush in 2nd cycle of a 5-cycle dwell on channel 3
    do_reset(8'b0000_1000, 8'd5);
    step();
    @(negedge clk);
    chk("s4_sel", int'(bus.sel), 3);
    step();
    bus.flush = 1'b1;
    bus.req = 8'hFF;
    @(negedge clk);
    chk("s4_nodone", int'(bus.done), 0);
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("s4_idle", int'(bus.active), 0);
    chk("s4_idle_done", int'(bus.done), 0);
    step();
    @(negedge clk);
    chk("s4_regrant", int'(bus.sel), 4);
    chk("s4_nowrap", int'(bus.wrap), 0);
    chk("s4_active", int'(bus.active), 1);

    // en dropped during a dwell on channel 5
    do_reset(8'b0010_0000, 8'd3);
    step();
    bus.en = 1'b0;
    @(negedge clk);
    chk("s5_sel", int'(bus.sel), 5);
    step();
    step();
    @(negedge clk);
    chk("s5_done", int'(bus.done), 1);
    step();
    bus.en = 1'b1;
    @(negedge clk);
    chk("s5_idle", int'(bus.active), 0);
    chk("s5_hold", int'(bus.sel), 5);
    step();
    @(negedge clk);
    chk("s5_regrant", int'(bus.active), 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("s5_async_sel", int'(bus.sel), 0);
    chk("s5_async_act", int'(bus.active), 0);
    chk("s5_async_dmx", int'(bus.demux_i), 0);

    // randomized traffic against the model
    do_reset(8'h00, 8'd1);
    for (int c = 0; c < 4000; c++) begin
      step();
      bus.en = ($urandom_range(0, 7) != 0);
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.dwell_len = 8'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: bus.req = 8'($urandom);
        1: bus.req = 8'($urandom & $urandom & $urandom);
        2: bus.req = 8'(1 << $urandom_range(0, 7));
        default: bus.req = 8'h00;
      endcase
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
